// File: rtl/conv_buf_pkg.sv
// rtl/conv_buf_pkg.sv - shared constants, word/set/slice types and geometry check
package conv_buf_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WR_WORDS   = 128;
  localparam int DEF_RD_WORDS   = 16;
  localparam int DEF_DEPTH      = 512;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
  typedef word_t [DEF_WR_WORDS-1:0]  set_t;
  typedef word_t [DEF_RD_WORDS-1:0]  slice_t;

  // True when every write set and read slice tiles the storage exactly, so
  // aligned pointers can never straddle the wrap point.
  function automatic bit geometry_ok(input int depth, input int wr_words, input int rd_words);
    return ((depth % wr_words) == 0) && ((depth % rd_words) == 0) && (depth >= wr_words);
  endfunction

endpackage

// File: rtl/conv_width_buffer_if.sv
// rtl/conv_width_buffer_if.sv - loader/multiplier side bus of the width-converting buffer
interface conv_width_buffer_if
  import conv_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WR_WORDS   = DEF_WR_WORDS,
  parameter int RD_WORDS   = DEF_RD_WORDS,
  parameter int DEPTH      = DEF_DEPTH
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                           flush;
  logic                           wen;
  logic [WR_WORDS*DATA_WIDTH-1:0] wdata;
  logic                           ren;
  logic [RD_WORDS*DATA_WIDTH-1:0] rdata;
  logic                           rdata_valid;
  logic                           full_flag;
  logic                           empty_flag;
  logic [CNT_W-1:0]               count;
  logic                           overflow;
  logic                           underflow;

  modport master (
    output flush, wen, wdata, ren,
    input  rdata, rdata_valid, full_flag, empty_flag, count, overflow, underflow
  );

  modport slave (
    input  flush, wen, wdata, ren,
    output rdata, rdata_valid, full_flag, empty_flag, count, overflow, underflow
  );

endinterface

// File: rtl/conv_buf_ptr_ctrl.sv
// rtl/conv_buf_ptr_ctrl.sv - pointers, occupancy, accept strobes and sticky error flags
module conv_buf_ptr_ctrl
  import conv_buf_pkg::*;
#(
  parameter int WR_WORDS = DEF_WR_WORDS,
  parameter int RD_WORDS = DEF_RD_WORDS,
  parameter int DEPTH    = DEF_DEPTH,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wen,
  input  logic             ren,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wp,
  output logic [PTR_W-1:0] rp,
  output logic [CNT_W-1:0] count,
  output logic             full_flag,
  output logic             empty_flag,
  output logic             overflow,
  output logic             underflow
);

  // Last aligned start position before each pointer wraps back to zero.
  localparam logic [PTR_W-1:0] WP_LAST = PTR_W'(DEPTH - WR_WORDS);
  localparam logic [PTR_W-1:0] RP_LAST = PTR_W'(DEPTH - RD_WORDS);

  assign full_flag  = count > CNT_W'(DEPTH - WR_WORDS);
  assign empty_flag = count < CNT_W'(RD_WORDS);
  assign wr_en      = wen & ~full_flag & ~flush;
  assign rd_en      = ren & ~empty_flag & ~flush;

  // Advance pointers and occupancy on accepted accesses; latch rejected requests as errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wp <= (wp == WP_LAST) ? '0 : wp + PTR_W'(WR_WORDS);
      end
      if (rd_en) begin
        rp <= (rp == RP_LAST) ? '0 : rp + PTR_W'(RD_WORDS);
      end
      count <= count + (wr_en ? CNT_W'(WR_WORDS) : '0) - (rd_en ? CNT_W'(RD_WORDS) : '0);
      if (wen & full_flag) begin
        overflow <= 1'b1;
      end
      if (ren & empty_flag) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_width_buffer.sv
// rtl/conv_width_buffer.sv - width-converting circular buffer, wide set in, narrow slice out
module conv_width_buffer
  import conv_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WR_WORDS   = DEF_WR_WORDS,
  parameter int RD_WORDS   = DEF_RD_WORDS,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  conv_width_buffer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if (!geometry_ok(DEPTH, WR_WORDS, RD_WORDS)) begin : g_bad_geometry
    $error("conv_width_buffer: DEPTH must be >= WR_WORDS and a multiple of both WR_WORDS and RD_WORDS");
  end

  logic                           wr_en;
  logic                           rd_en;
  logic [PTR_W-1:0]               wp;
  logic [PTR_W-1:0]               rp;
  logic [CNT_W-1:0]               count_w;
  logic [DEPTH*DATA_WIDTH-1:0]    mem;
  logic [RD_WORDS*DATA_WIDTH-1:0] rdata_q;
  logic                           rdata_valid_q;

  conv_buf_ptr_ctrl #(
    .WR_WORDS (WR_WORDS),
    .RD_WORDS (RD_WORDS),
    .DEPTH    (DEPTH)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.flush),
    .wen        (bus.wen),
    .ren        (bus.ren),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wp         (wp),
    .rp         (rp),
    .count      (count_w),
    .full_flag  (bus.full_flag),
    .empty_flag (bus.empty_flag),
    .overflow   (bus.overflow),
    .underflow  (bus.underflow)
  );

  // Word-addressed storage: demux an accepted set into WR_WORDS consecutive words at wp.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WR_WORDS; i++) begin
        mem[(int'(wp) + i)*DATA_WIDTH +: DATA_WIDTH] <= bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read mux into the output register; sees pre-edge storage, so same-cycle writes never bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      rdata_valid_q <= rd_en;
      if (rd_en) begin
        for (int i = 0; i < RD_WORDS; i++) begin
          rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[(int'(rp) + i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.count       = count_w;

endmodule
